pc_fetch: RTL

Program-counter and status-register stage for the single-cycle 8-bit core. It sits directly upstream of the ALU: it holds the flag and overflow bits the ALU reads as FLAG_IN/OVERFLOW_IN and captures the ALU's FLAG_OUT/OVERFLOW_OUT. It also consumes FLAG_BRANCH_EN to choose between sequential fetch and a table-driven branch. A small start/run/done state machine brackets each program run for the testbench.

---
 rtl/pc_fetch_pkg.sv | 31 +++
 rtl/pc_fetch_branch_lut.sv | 31 +++
 rtl/pc_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared definitions for the program-counter / status stage:
//               address widths, fetch state encoding and the named branch
//               targets that fill the branch table.
// Config      : PC_CYCLE_COUNT_EN (used by pc_fetch, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    localparam int PC_W  = 10;
    localparam int LUT_W = 5;

    // Run bracket seen by the testbench: IDLE -> RUN -> DONE -> RUN ...
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fetch_state_t;

    // Named absolute branch targets for the current program set
    localparam logic [PC_W-1:0] BR_TGT_LOOP  = 10'd16;
    localparam logic [PC_W-1:0] BR_TGT_MULT  = 10'd64;
    localparam logic [PC_W-1:0] BR_TGT_SHIFT = 10'd100;
    localparam logic [PC_W-1:0] BR_TGT_EXIT  = 10'd200;
    localparam logic [PC_W-1:0] BR_TGT_DATA  = 10'd512;
    localparam logic [PC_W-1:0] BR_TGT_LAST  = 10'd1023;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_branch_lut
// Description : Combinational branch target ROM. Indexed by the instruction's
//               branch field; unprogrammed entries read zero. Swapping this
//               file changes the target table without touching pc_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_branch_lut
    import pc_fetch_pkg::*;
(
    input  logic [LUT_W-1:0] idx_i,
    output logic [PC_W-1:0]  target_o
);

    // Table lookup; anything not listed falls through to address 0
    always_comb begin
        target_o = '0;
        case (idx_i)
            5'd0:    target_o = BR_TGT_LOOP;
            5'd1:    target_o = BR_TGT_MULT;
            5'd2:    target_o = BR_TGT_SHIFT;
            5'd3:    target_o = BR_TGT_EXIT;
            5'd7:    target_o = BR_TGT_DATA;
            5'd31:   target_o = BR_TGT_LAST;
            default: target_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Program counter and ALU status registers for the single-cycle
//               8-bit core, with a start/run/done bracket around each run.
//               Branches resolve in the same cycle (no delay slot).
// Config      : PC_CYCLE_COUNT_EN adds the saturating CYCLES run counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [PC_W-1:0]  START_ADDR,
    input  logic             HALT,
    input  logic             STALL,
    input  logic             FLAG_BRANCH_EN,
    input  logic [LUT_W-1:0] BRANCH_IDX,
    input  logic             STATUS_WE,
    input  logic             FLAG_D,
    input  logic             OVERFLOW_D,
    output logic [PC_W-1:0]  PC,
    output logic             FLAG_Q,
    output logic             OVERFLOW_Q,
    output logic             RUNNING,
    output logic             DONE
`ifdef PC_CYCLE_COUNT_EN
    ,
    output logic [15:0]      CYCLES
`endif
);

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_q, flag_d;
    logic            ovf_q, ovf_d;
    logic [PC_W-1:0] w_target;

    pc_fetch_branch_lut u_branch_lut (
        .idx_i    (BRANCH_IDX),
        .target_o (w_target)
    );

    // Next state for FSM, PC and status: HALT > STALL > branch > increment
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    flag_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (HALT) begin
                    state_d = S_DONE;
                end else if (!STALL) begin
                    pc_d = FLAG_BRANCH_EN ? w_target : (pc_q + c_PC_ONE);
                    if (STATUS_WE) begin
                        flag_d = FLAG_D;
                        ovf_d  = OVERFLOW_D;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PC_CYCLE_COUNT_EN
    logic [15:0] cycles_q, cycles_d;

    // Count every non-HALT RUN cycle (stalls included), saturate at all-ones,
    // clear on an accepted START
    always_comb begin
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    cycles_d = '0;
                end
            end
            S_RUN: begin
                if (!HALT && (cycles_q != 16'hFFFF)) begin
                    cycles_d = cycles_q + 16'd1;
                end
            end
            default: cycles_d = cycles_q;
        endcase
    end

    // Run cycle counter register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign CYCLES = cycles_q;
`endif

    assign PC         = pc_q;
    assign FLAG_Q     = flag_q;
    assign OVERFLOW_Q = ovf_q;
    assign RUNNING    = (state_q == S_RUN);
    assign DONE       = (state_q == S_DONE);

endmodule
`default_nettype wire
